// File: rtl/cpu_pkg.sv
// Shared CPU definitions: encoding of the memory response owner.
package cpu_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between fetch and load/store,
// data side first, with a bounded fetch-starvation counter.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_SIZE  = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_SIZE-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [XLEN-1:0]      if_rdata,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [ADDR_SIZE-1:0] dm_addr,
    input  logic [XLEN-1:0]      dm_wdata,
    output logic                 dm_gnt,
    output logic                 dm_rvalid,
    output logic [XLEN-1:0]      dm_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic [1:0] rsp_own;
    logic       if_win;

    // Fetch wins alone, or on contention once it has starved long enough.
    always_comb begin
        if_win = if_req && (!dm_req || starve_cnt == SMAX);
        if_gnt = !rst && if_win;
        dm_gnt = !rst && dm_req && !if_win;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (if_req && starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Stores and idle cycles leave no response pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_own <= OWN_NONE;
        end else if (if_gnt) begin
            rsp_own <= OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            rsp_own <= OWN_DM;
        end else begin
            rsp_own <= OWN_NONE;
        end
    end

    always_comb begin
        if_rvalid = (rsp_own == OWN_IF);
        dm_rvalid = (rsp_own == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a behavioural
// synchronous-read memory.
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            dm_req;
    logic            dm_we;
    logic [AW-1:0]   dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] dm_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [XLEN-1:0] mem [32];
    logic [31:0]     written = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN), .ADDR_SIZE(AW), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [XLEN-1:0] dflt(input logic [AW-1:0] a);
        if (a == 5'd3) return 32'hDEAD_BEEF;
        return 32'hA000_0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? mem[mem_addr]
                                               : dflt(mem_addr);
            end
        end
    end

    task automatic test_reset;
        logic [XLEN*4+AW+7:0] all;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 5'd3;
        #1;
        all = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata};
        vectors++;
        if (all !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", all);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (if_gnt !== 1'b1 || mem_addr !== 5'd3) begin
            miscompares++;
            $display("FAIL reset_fetch_gnt got gnt=%b addr=%0d want 1/3",
                     if_gnt, mem_addr);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (if_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_rvalid got %b want 1", if_rvalid);
        end
        rst = 1'b1;
        #1;
        all = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata};
        vectors++;
        if (all !== '0) begin
            miscompares++;
            $display("FAIL reset_midread got %h want 0", all);
        end
        @(negedge clk);
        if_req = 1'b0;
        rst    = 1'b0;
        #1;
        vectors++;
        if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_rvalid got %b%b want 00",
                     if_rvalid, dm_rvalid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_after_rvalid got %b%b want 00",
                     if_rvalid, dm_rvalid);
        end
    endtask

    task automatic test_fetch;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 5'd3;
        #1;
        vectors++;
        if ({if_gnt, dm_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 5'd3})
        begin
            miscompares++;
            $display("FAIL fetch_cmd got %b%b%b%b a=%0d want 1010 a=3",
                     if_gnt, dm_gnt, mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        vectors++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL fetch_rdata got v=%b d=%h want 1 deadbeef",
                     if_rvalid, if_rdata);
        end
        vectors++;
        if (dm_rvalid !== 1'b0 || dm_rdata !== '0) begin
            miscompares++;
            $display("FAIL fetch_dm_quiet got v=%b d=%h want 0 0",
                     dm_rvalid, dm_rdata);
        end
    endtask

    task automatic test_store_load;
        @(negedge clk);
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 5'd7;
        dm_wdata = 32'h0000_1234;
        #1;
        vectors++;
        if ({dm_gnt, if_gnt, mem_en, mem_we} !== 4'b1011 ||
            mem_addr !== 5'd7 || mem_wdata !== 32'h1234) begin
            miscompares++;
            $display("FAIL store_cmd got %b%b%b%b a=%0d d=%h want 1011 7 1234",
                     dm_gnt, if_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        dm_we    = 1'b0;
        dm_wdata = '0;
        #1;
        vectors++;
        if (dm_gnt !== 1'b1 || mem_we !== 1'b0 ||
            if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_cmd got g=%b we=%b rv=%b%b want 1 0 00",
                     dm_gnt, mem_we, if_rvalid, dm_rvalid);
        end
        @(negedge clk);
        dm_req = 1'b0;
        #1;
        vectors++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h1234 ||
            if_rdata !== '0) begin
            miscompares++;
            $display("FAIL load_rdata got v=%b d=%h if=%h want 1 1234 0",
                     dm_rvalid, dm_rdata, if_rdata);
        end
    endtask

    task automatic test_contention;
        logic [1:0] want;
        // Build up starvation, then show reset clears it.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_req  = 1'b1;
            if_addr = 5'd4;
            dm_req  = 1'b1;
            dm_we   = 1'b0;
            dm_addr = 5'd12;
        end
        @(negedge clk);
        if_req = 1'b0;
        dm_req = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if_req = 1'b1;
            dm_req = 1'b1;
            #1;
            want = (i == 4) ? 2'b10 : 2'b01;
            vectors++;
            if ({if_gnt, dm_gnt} !== want) begin
                miscompares++;
                $display("FAIL contention_c%0d got %b want %b",
                         i, {if_gnt, dm_gnt}, want);
            end
            if (i == 1) begin
                vectors++;
                if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hA000_000C) begin
                    miscompares++;
                    $display("FAIL contention_dm_rd got %b %h want 1 a000000c",
                             dm_rvalid, dm_rdata);
                end
            end
            if (i == 5) begin
                vectors++;
                if (if_rvalid !== 1'b1 || if_rdata !== 32'hA000_0004) begin
                    miscompares++;
                    $display("FAIL contention_if_rd got %b %h want 1 a0000004",
                             if_rvalid, if_rdata);
                end
            end
        end
        @(negedge clk);
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [1:0]      wg;
        logic [AW-1:0]   pa;
        logic [XLEN-1:0] pd;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if_req = (k < 8) && (k % 2 == 0);
            dm_req = (k < 8) && (k % 2 == 1);
            dm_we  = 1'b0;
            if_addr = AW'(16 + k);
            dm_addr = AW'(16 + k);
            #1;
            if (k < 8) begin
                wg = (k % 2 == 0) ? 2'b10 : 2'b01;
                vectors++;
                if ({if_gnt, dm_gnt} !== wg) begin
                    miscompares++;
                    $display("FAIL b2b_gnt_%0d got %b want %b",
                             k, {if_gnt, dm_gnt}, wg);
                end
            end
            if (k > 0) begin
                pa = AW'(16 + k - 1);
                pd = 32'hA000_0000 | 32'(pa);
                wg = ((k - 1) % 2 == 0) ? 2'b10 : 2'b01;
                vectors++;
                if ({if_rvalid, dm_rvalid} !== wg ||
                    (if_rdata | dm_rdata) !== pd) begin
                    miscompares++;
                    $display("FAIL b2b_rsp_%0d got %b %h want %b %h",
                             k, {if_rvalid, dm_rvalid},
                             if_rdata | dm_rdata, wg, pd);
                end
            end
        end
    endtask

    task automatic test_mutex;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            if_req   = 1'($urandom);
            dm_req   = 1'($urandom);
            dm_we    = 1'($urandom);
            if_addr  = AW'($urandom);
            dm_addr  = AW'($urandom);
            dm_wdata = $urandom;
            #1;
            vectors++;
            if ((if_gnt && dm_gnt) || mem_en !== (if_gnt | dm_gnt) ||
                (if_rvalid && dm_rvalid)) begin
                miscompares++;
                $display("FAIL mutex_%0d got g=%b%b en=%b rv=%b%b",
                         n, if_gnt, dm_gnt, mem_en, if_rvalid, dm_rvalid);
            end
        end
        @(negedge clk);
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_mutex();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares one single-ported, synchronous-read memory between the instruction-fetch requester and the load/store requester of the CPU. It issues at most one memory access per cycle, gives load/store priority, and bounds fetch starvation with a counter. It returns read data to the owning requester one cycle after grant. It sits between the fetch/memory stages and a unified memory macro, replacing the separate instruction and data stores.

## Interface
- XLEN, 32, data width
- ADDR_SIZE, 5, word-address width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch wins contention (1..15)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_SIZE  fetch word address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  XLEN  fetch read data; 0 when if_rvalid=0
- dm_req  in  1  load/store request; held with dm_we/dm_addr/dm_wdata stable until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_SIZE  data word address
- dm_wdata  in  XLEN  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  dm_rdata valid (loads only)
- dm_rdata  out  XLEN  load data; 0 when dm_rvalid=0
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_SIZE  memory address
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data, valid the cycle after a read with mem_en=1, mem_we=0

## Operation
- Grant decision is combinational each cycle from if_req, dm_req and the starvation count. At most one of if_gnt/dm_gnt is high.
- Only one request: it is granted.
- Both requests: dm wins unless starve_cnt == STARVE_MAX, then if wins.
- starve_cnt (4 bits): increments when if_req=1 and if_gnt=0, saturating at STARVE_MAX. Clears to 0 on any if_gnt. Holds when if_req=0.
- On grant: mem_en=1, and mem_addr/mem_we/mem_wdata come from the winner. A fetch drives mem_we=0 and mem_wdata=0. With no grant, mem_en=mem_we=0, mem_addr=0 and mem_wdata=0.
- Response-owner register rsp_own ∈ {NONE, IF, DM} is loaded each cycle:
  - IF on if_gnt
  - DM on a dm_gnt with dm_we=0
  - NONE otherwise, which covers stores and idle cycles
- if_rvalid = (rsp_own==IF) and dm_rvalid = (rsp_own==DM). Data is mem_rdata routed to the owner and forced to 0 for the non-owner.
- Stores produce no rvalid.

## Timing
- Grant and memory command: same cycle as the request (0-cycle latency).
- Read data and rvalid: cycle N+1 for a grant in cycle N. Back-to-back grants are allowed, giving 1 access/cycle throughput.
- Reset: rsp_own=NONE and starve_cnt=0. Every output is 0 while rst=1 (grants masked), so all memory controls are deasserted.
- Reset mid-operation: any pending response is discarded, so no rvalid appears after rst deasserts.
- Simultaneous requests while starve_cnt==STARVE_MAX: the fetch is granted, the counter clears and the dm request waits one cycle.
- Requesters must not drop req before gnt; behaviour when they do is unspecified but must not produce two grants in one cycle.

## Structure
- Shared package cpu_pkg holds the rsp_own encoding: localparams OWN_NONE=2'd0, OWN_IF=2'd1, OWN_DM=2'd2.
- Single module. The starvation counter is small enough to stay inline, so no sub-module.

## Test plan
- Reset: assert rst mid-read (rsp_own=IF) -> all outputs 0 immediately. After release no if_rvalid, and starve_cnt=0.
- Fetch only: if_req=1 for addr 3 with mem[3]=0xDEAD_BEEF -> if_gnt same cycle, then if_rvalid=1 with if_rdata=0xDEADBEEF next cycle, dm_rdata=0.
- Store then load: dm store addr 7 data 0x1234 -> dm_gnt=1, mem_we=1 and no rvalid. The next-cycle load of addr 7 -> dm_rvalid=1 with dm_rdata=0x1234 one cycle later.
- Contention: both req held for 6 cycles, STARVE_MAX=4 -> dm granted cycles 0-3, if granted cycle 4, dm granted cycle 5, starve_cnt back to 0 after cycle 4.
- Back-to-back: alternating if/dm loads every cycle -> one grant per cycle. rvalid alternates if/dm with no bubble and the data matches the addresses.
- Mutual exclusion (random req/we over 10k cycles) -> never two grants in one cycle, and mem_en == (if_gnt|dm_gnt) always.
